fetch_stall_responder: RTL and testbench
========================================

Name: fetch_stall_responder

Overview:
- Consumes the stall requests from the hazard detection unit (PCWrite, IF_ID_Write, Sel) and applies them to the front of the 5-stage MIPS pipeline.
- Holds the PC register, the IF/ID pipeline register and the control half of the ID/EX register, where it inserts bubbles.
- Also flushes IF/ID on a taken branch resolved in ID, keeps stall/flush performance counters, and runs a watchdog that flags stalls longer than any legal hazard allows.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 10, width of the ID-stage control bundle forwarded to ID/EX
CNT_W, 16, width of the performance counters
MAX_STALL, 3, consecutive-stall count that raises StallTimeout; legal maximum is 2 (lw followed by beq/bne)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
PCWrite  in  1  1 = PC may update
IF_ID_Write  in  1  1 = IF/ID may update
Sel  in  1  0 = insert bubble into ID/EX control
PCSrc  in  1  branch taken, resolved in ID
BranchTarget  in  32  taken-branch target
Instr_in  in  32  instruction memory output for current PC
ID_Ctrl_in  in  CTRL_W  decoded control for instruction in ID
PC  out  32  current fetch address
IF_ID_Instr  out  32  latched instruction
IF_ID_PCPlus4  out  32  latched PC+4
IF_ID_Valid  out  1  IF/ID holds a real instruction
ID_EX_Ctrl  out  CTRL_W  registered control into EX
StallCount  out  CNT_W  total cycles with PCWrite=0, saturating
FlushCount  out  CNT_W  total IF/ID flushes, saturating
StallTimeout  out  1  sticky watchdog flag

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: PC=RESET_PC; IF_ID_Instr=0 (nop); IF_ID_PCPlus4=0; IF_ID_Valid=0; ID_EX_Ctrl=0; StallCount=0; FlushCount=0; StallTimeout=0; internal run counter=0.
- rst overrides every other input in the same edge.
- All outputs are registered. Every input takes effect at the next rising edge (1-cycle latency).
- PC update, in priority order:
  - PCWrite=0: hold. PCSrc is ignored; the hazard unit guarantees the branch re-evaluates after the stall.
  - else PCSrc=1: PC <= BranchTarget.
  - else PC <= PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID update, in priority order:
  - IF_ID_Write=0: hold all three fields.
  - else PCSrc=1: flush. IF_ID_Instr <= 0, IF_ID_Valid <= 0, IF_ID_PCPlus4 <= PC+4. FlushCount increments.
  - else IF_ID_Instr <= Instr_in, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
- ID/EX control: Sel=0 -> ID_EX_Ctrl <= 0 (bubble); else ID_EX_Ctrl <= ID_Ctrl_in. This is independent of the PCWrite/IF_ID_Write states.
- Run counter:
  - Counts consecutive cycles with PCWrite=0 and clears to 0 on any cycle with PCWrite=1.
  - Saturates at MAX_STALL.
  - When the counter, including the current stalled cycle, reaches MAX_STALL, StallTimeout <= 1. StallTimeout stays set until rst.
- StallCount increments on every PCWrite=0 cycle. StallCount and FlushCount saturate at all-ones and do not wrap.
- Mismatched stall inputs (PCWrite != IF_ID_Write) are legal; each register obeys its own enable.
- Reset mid-stall clears the run counter; the pipeline restarts fetching at RESET_PC.

Decomposition:
- Shared package mips_pipe_pkg:
  - NOP_INSTR = 32'h0.
  - CTRL_W.
  - Control-bundle bit positions (RegWrite, MemRead, MemWrite, Branch, BranchNot, ...).
  - RESET_PC default.
- One sub-module is natural: sat_counter (parameter width; inputs inc, clr; output value). Instantiate it three times: StallCount, FlushCount, and the run counter with saturation at MAX_STALL.

Test Plan:
- Reset, then 4 cycles with all enables=1, Sel=1, PCSrc=0 -> PC 0,4,8,12,16. IF_ID_PCPlus4 trails PC by one cycle; IF_ID_Valid=1 from cycle 1.
- Load-use stall: one cycle with PCWrite=IF_ID_Write=Sel=0 at PC=8, ID_Ctrl_in=10'h3FF -> PC holds 8 for one cycle, IF/ID holds, ID_EX_Ctrl=0. Then resumes to 12. StallCount=1, StallTimeout=0.
- lw then beq: two consecutive stall cycles -> StallCount=2, StallTimeout=0. Three consecutive stall cycles -> StallTimeout=1 after the third edge and remains 1 after stalls end.
- Taken branch: PCSrc=1, BranchTarget=32'h40, enables=1 -> next PC=0x40, IF_ID_Instr=0, IF_ID_Valid=0, FlushCount=1.
- PCSrc=1 together with PCWrite=IF_ID_Write=0 -> PC and IF/ID hold, FlushCount unchanged. Same branch on the next cycle with enables=1 -> redirect to target.
- PC=32'hFFFF_FFFC free-running -> PC=0. Counter saturation (CNT_W=4): 20 stalls -> StallCount=15. rst asserted mid-stall -> all outputs at reset values next edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared definitions for the front of the 5-stage MIPS pipeline: the nop
//   encoding, the width and bit layout of the ID-stage control bundle that is
//   forwarded into ID/EX, and the default reset fetch address.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          CTRL_W    = 10;

   // Bit positions inside the ID-stage control bundle.
   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_MEM_READ   = 1;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_BRANCH     = 3;
   localparam int CTRL_BRANCH_NOT = 4;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_ALU_SRC    = 6;
   localparam int CTRL_REG_DST    = 7;
   localparam int CTRL_ALU_OP_LO  = 8;
   localparam int CTRL_ALU_OP_HI  = 9;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage : mips_pipe_pkg

// File: rtl/fetch_stall_responder_if.sv
// -----------------------------------------------------------------------------
// fetch_stall_responder_if
//   Bundles the stall/branch requests from the hazard unit and ID stage with
//   the front-end pipeline state they control.
//   master : hazard unit / ID stage / instruction memory side (drives requests)
//   slave  : fetch_stall_responder (drives PC, IF/ID, ID/EX control, counters)
//   Requests : PCWrite, IF_ID_Write, Sel, PCSrc, BranchTarget, Instr_in,
//              ID_Ctrl_in
//   State    : PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl,
//              StallCount, FlushCount, StallTimeout
// -----------------------------------------------------------------------------
interface fetch_stall_responder_if
   import mips_pipe_pkg::*;
#(
   parameter int P_CTRL_W = CTRL_W,
   parameter int P_CNT_W  = 16
);

   logic                PCWrite;
   logic                IF_ID_Write;
   logic                Sel;
   logic                PCSrc;
   logic [31:0]         BranchTarget;
   logic [31:0]         Instr_in;
   logic [P_CTRL_W-1:0] ID_Ctrl_in;

   logic [31:0]         PC;
   logic [31:0]         IF_ID_Instr;
   logic [31:0]         IF_ID_PCPlus4;
   logic                IF_ID_Valid;
   logic [P_CTRL_W-1:0] ID_EX_Ctrl;
   logic [P_CNT_W-1:0]  StallCount;
   logic [P_CNT_W-1:0]  FlushCount;
   logic                StallTimeout;

   modport master (
      output PCWrite, IF_ID_Write, Sel, PCSrc, BranchTarget, Instr_in, ID_Ctrl_in,
      input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl,
             StallCount, FlushCount, StallTimeout
   );

   modport slave (
      input  PCWrite, IF_ID_Write, Sel, PCSrc, BranchTarget, Instr_in, ID_Ctrl_in,
      output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl,
             StallCount, FlushCount, StallTimeout
   );

endinterface : fetch_stall_responder_if

// File: rtl/fetch_stall_responder_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at MAX instead of wrapping. clr has priority over
//   inc; rst has priority over both.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (value -> 0)
//   inc_i   : count this cycle
//   clr_i   : clear to 0 this cycle
//   value_o : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int           W   = 16,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] value_o
);

   logic [W-1:0] value_q, value_d;

   // NOTE: combinational next-state assigns a default first so every path
   // drives value_d and no latch is inferred.
   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (inc_i && (value_q != MAX)) begin
         value_d = value_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) value_q <= '0;
      else     value_q <= value_d;
   end

   assign value_o = value_q;

endmodule : sat_counter

// File: rtl/fetch_stall_responder.sv
// -----------------------------------------------------------------------------
// fetch_stall_responder
//   Applies hazard-unit stall requests to the front of the pipeline. Owns the
//   PC, the IF/ID register and the control half of ID/EX (bubble insertion),
//   flushes IF/ID on a branch taken in ID, counts stall cycles and flushes,
//   and raises a sticky watchdog when a stall lasts MAX_STALL cycles.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, overrides all other inputs
//   bus : fetch_stall_responder_if.slave (requests in, pipeline state out)
// -----------------------------------------------------------------------------
module fetch_stall_responder
   import mips_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pipe_pkg::RESET_PC,
   parameter int          CTRL_W    = mips_pipe_pkg::CTRL_W,
   parameter int          CNT_W     = 16,
   parameter int          MAX_STALL = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   fetch_stall_responder_if.slave   bus
);

   // Run counter only needs to reach MAX_STALL.
   localparam int RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

   logic [31:0]       pc_q,       pc_d;
   logic [31:0]       instr_q,    instr_d;
   logic [31:0]       pcplus4_q,  pcplus4_d;
   logic              valid_q,    valid_d;
   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
   logic              timeout_q,  timeout_d;

   logic [31:0]       seq_pc;
   logic              flush;
   logic [RUN_W-1:0]  run_cnt;
   logic [RUN_W:0]    run_incl;

   assign seq_pc = pc_plus4(pc_q);
   // A flush only happens when IF/ID is allowed to update.
   assign flush  = bus.IF_ID_Write && bus.PCSrc;
   // Run length including the current cycle when it is stalled.
   assign run_incl = {1'b0, run_cnt} + 1'b1;

   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      ctrl_d    = bus.Sel ? bus.ID_Ctrl_in : '0;
      timeout_d = timeout_q;

      // A held PC ignores PCSrc; the branch is re-evaluated after the stall.
      if (bus.PCWrite) begin
         pc_d = bus.PCSrc ? bus.BranchTarget : seq_pc;
      end

      if (bus.IF_ID_Write) begin
         pcplus4_d = seq_pc;
         if (bus.PCSrc) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else begin
            instr_d = bus.Instr_in;
            valid_d = 1'b1;
         end
      end

      if (!bus.PCWrite && (run_incl >= (RUN_W+1)'(MAX_STALL))) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         pcplus4_q <= '0;
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (!bus.PCWrite),
      .clr_i   (1'b0),
      .value_o (bus.StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (flush),
      .clr_i   (1'b0),
      .value_o (bus.FlushCount)
   );

   sat_counter #(.W(RUN_W), .MAX(RUN_W'(MAX_STALL))) u_run_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (!bus.PCWrite),
      .clr_i   (bus.PCWrite),
      .value_o (run_cnt)
   );

   assign bus.PC            = pc_q;
   assign bus.IF_ID_Instr   = instr_q;
   assign bus.IF_ID_PCPlus4 = pcplus4_q;
   assign bus.IF_ID_Valid   = valid_q;
   assign bus.ID_EX_Ctrl    = ctrl_q;
   assign bus.StallTimeout  = timeout_q;

endmodule : fetch_stall_responder

// File: tb/tb_fetch_stall_responder.sv
// -----------------------------------------------------------------------------
// tb_fetch_stall_responder
//   Directed test-plan sequences followed by randomized stimulus, all checked
//   against a cycle-level behavioural model of the fetch front end. Counters
//   use CNT_W=4 so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fetch_stall_responder;

   localparam int CTRL_W    = 10;
   localparam int CNT_W     = 4;
   localparam int MAX_STALL = 3;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_stall_responder_if #(.P_CTRL_W(CTRL_W), .P_CNT_W(CNT_W)) bus ();

   fetch_stall_responder #(
      .RESET_PC  (32'h0000_0000),
      .CTRL_W    (CTRL_W),
      .CNT_W     (CNT_W),
      .MAX_STALL (MAX_STALL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0]       m_pc;
   logic [31:0]       m_instr;
   logic [31:0]       m_pc4;
   logic              m_valid;
   logic [CTRL_W-1:0] m_ctrl;
   int                m_stalls;
   int                m_flushes;
   int                m_run;
   logic              m_timeout;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic check_all();
      check("pc",          bus.PC,                       m_pc);
      check("ifid_instr",  bus.IF_ID_Instr,              m_instr);
      check("ifid_pc4",    bus.IF_ID_PCPlus4,            m_pc4);
      check("ifid_valid",  32'(bus.IF_ID_Valid),         32'(m_valid));
      check("idex_ctrl",   32'(bus.ID_EX_Ctrl),          32'(m_ctrl));
      check("stall_count", 32'(bus.StallCount),          32'(m_stalls));
      check("flush_count", 32'(bus.FlushCount),          32'(m_flushes));
      check("timeout",     32'(bus.StallTimeout),        32'(m_timeout));
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_step();
      logic [31:0] next_seq;
      if (rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_ctrl = '0; m_stalls = 0; m_flushes = 0; m_run = 0; m_timeout = 1'b0;
      end else begin
         next_seq = m_pc + 32'd4;
         if (bus.IF_ID_Write) begin
            m_pc4 = next_seq;
            if (bus.PCSrc) begin
               m_instr = 32'h0;
               m_valid = 1'b0;
               if (m_flushes < CNT_MAX) m_flushes++;
            end else begin
               m_instr = bus.Instr_in;
               m_valid = 1'b1;
            end
         end
         if (bus.PCWrite) m_pc = bus.PCSrc ? bus.BranchTarget : next_seq;
         m_ctrl = bus.Sel ? bus.ID_Ctrl_in : '0;
         if (!bus.PCWrite) begin
            m_run++;
            if (m_run >= MAX_STALL) m_timeout = 1'b1;
            if (m_stalls < CNT_MAX) m_stalls++;
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic pcw, input logic ifw, input logic sel,
                       input logic src, input logic [31:0] tgt,
                       input logic [31:0] instr, input logic [CTRL_W-1:0] ctrl);
      rst              = r;
      bus.PCWrite      = pcw;
      bus.IF_ID_Write  = ifw;
      bus.Sel          = sel;
      bus.PCSrc        = src;
      bus.BranchTarget = tgt;
      bus.Instr_in     = instr;
      bus.ID_Ctrl_in   = ctrl;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run1(input logic [31:0] instr);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, instr, 10'h155);
   endtask

   task automatic stall1();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 10'h3FF);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, '0);
   endtask

   initial begin
      rst = 1'b1;
      bus.PCWrite = 1'b1; bus.IF_ID_Write = 1'b1; bus.Sel = 1'b1; bus.PCSrc = 1'b0;
      bus.BranchTarget = '0; bus.Instr_in = '0; bus.ID_Ctrl_in = '0;

      // Reset state
      do_reset();
      check("reset_pc", bus.PC, 32'h0);

      // Free-running fetch 0,4,8,12,16
      for (int i = 0; i < 4; i++) run1(32'h1000 + 32'(i));
      check("seq_pc16", bus.PC, 32'd16);
      check("seq_pc4_trail", bus.IF_ID_PCPlus4, 32'd16);

      // Load-use: single stall at PC=8
      do_reset();
      run1(32'hA); run1(32'hB);
      stall1();
      check("lu_pc_hold", bus.PC, 32'd8);
      check("lu_bubble", 32'(bus.ID_EX_Ctrl), 32'h0);
      run1(32'hC);
      check("lu_resume", bus.PC, 32'd12);
      check("lu_stalls", 32'(bus.StallCount), 32'd1);

      // Two stalls legal, three trip the watchdog
      do_reset();
      stall1(); stall1();
      check("two_stall_to", 32'(bus.StallTimeout), 32'd0);
      run1(32'h1);
      stall1(); stall1(); stall1();
      check("three_stall_to", 32'(bus.StallTimeout), 32'd1);
      run1(32'h2); run1(32'h3);
      check("to_sticky", 32'(bus.StallTimeout), 32'd1);

      // Taken branch flushes IF/ID
      do_reset();
      run1(32'h7);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h8, 10'h1);
      check("br_pc", bus.PC, 32'h40);
      check("br_flush_cnt", 32'(bus.FlushCount), 32'd1);

      // Branch during stall is ignored, then taken next cycle
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h9, 10'h2);
      check("br_stall_pc", bus.PC, 32'h40);
      check("br_stall_flush", 32'(bus.FlushCount), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h9, 10'h2);
      check("br_after_stall", bus.PC, 32'h80);

      // Mismatched enables
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h11, 10'h3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h12, 10'h4);

      // PC wrap
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 10'h0);
      run1(32'h5);
      check("pc_wrap", bus.PC, 32'h0);

      // Stall counter saturation, then reset mid-stall
      for (int i = 0; i < 20; i++) stall1();
      check("stall_sat", 32'(bus.StallCount), 32'(CNT_MAX));
      do_reset();
      check("rst_mid_stall_to", 32'(bus.StallTimeout), 32'd0);
      stall1(); stall1();
      check("rst_run_cleared", 32'(bus.StallTimeout), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic pcw, ifw;
         pcw = ($urandom_range(0, 3) != 0);
         ifw = ($urandom_range(0, 7) == 0) ? ~pcw : pcw;
         step(($urandom_range(0, 59) == 0),
              pcw, ifw,
              ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 5) == 0),
              {$urandom} & 32'hFFFF_FFFC,
              $urandom,
              CTRL_W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_stall_responder
